// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot palette path.
//   rgb_t          : one 8:8:8 palette entry
//   loader_state_t : palette loader FSM states
//   INSIDE_COLOUR_DEF : colour for points that never escaped
package mandel_pkg;

   localparam int RGB_SIZE_DEF = 24;

   typedef logic [RGB_SIZE_DEF-1:0] rgb_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      DRAIN   = 2'd2,
      PENDING = 2'd3
   } loader_state_t;

   localparam rgb_t INSIDE_COLOUR_DEF = 24'h000000;

endpackage

// File: rtl/palette_bank.sv
// One palette bank: single write port, NUM_RD registered read ports.
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : per-port read addresses (must be < DEPTH)
//   rdata_o   : per-port read data, one cycle after raddr_i
// Contents are not reset.
module palette_bank #(
   parameter int RGB_SIZE = 24,
   parameter int DEPTH    = 50,
   parameter int NUM_RD   = 3,
   parameter int AW       = 6
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [AW-1:0]       waddr_i,
   input  logic [RGB_SIZE-1:0] wdata_i,
   input  logic [AW-1:0]       raddr_i [NUM_RD],
   output logic [RGB_SIZE-1:0] rdata_o [NUM_RD]
);

   logic [RGB_SIZE-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_RD; i++) begin
         rdata_o[i] <= mem_q[raddr_i[i]];
      end
   end

endmodule

// File: rtl/palette_loader.sv
// Runtime palette loader with double-buffered palette RAM.
// Host entries arrive on an AXI-Stream-like port and fill the shadow bank;
// a complete palette is committed (banks swapped) only on frame_sync, so
// the pixel engines never observe a half-written palette.
//   aclk, aresetn  : clock, async active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast : palette entry stream
//   frame_sync     : frame boundary strobe, commits a pending palette
//   iterations[i]  : engine lookup index
//   rgb_val[i]     : looked-up colour, one cycle latency
//   palette_valid  : a palette has been committed since reset
//   load_busy      : loader is mid-palette or waiting to commit
//   load_error     : one-cycle pulse on a short or long palette
module palette_loader
   import mandel_pkg::*;
#(
   parameter int                  DATA_WIDTH    = 32,
   parameter int                  RGB_SIZE      = RGB_SIZE_DEF,
   parameter int                  MAX_ITERATION = 50,
   parameter int                  NUM_ENGINES   = 3,
   parameter logic [RGB_SIZE-1:0] INSIDE_COLOUR = INSIDE_COLOUR_DEF
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [RGB_SIZE-1:0]   s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic                  frame_sync,
   input  logic [DATA_WIDTH-1:0] iterations [NUM_ENGINES],
   output logic [RGB_SIZE-1:0]   rgb_val    [NUM_ENGINES],
   output logic                  palette_valid,
   output logic                  load_busy,
   output logic                  load_error
);

   localparam int IDX_WIDTH = (MAX_ITERATION > 1) ? $clog2(MAX_ITERATION) : 1;
   localparam logic [IDX_WIDTH-1:0]  LAST_IDX   = IDX_WIDTH'(MAX_ITERATION - 1);
   localparam logic [DATA_WIDTH-1:0] MAX_ITER_W = DATA_WIDTH'(MAX_ITERATION);

   loader_state_t        state_q, state_d;
   logic [IDX_WIDTH-1:0] wr_idx_q, wr_idx_d;
   logic                 bank_q, bank_d;       // active (read) bank
   logic                 pal_valid_q, pal_valid_d;
   logic                 err_q, err_d;
   logic                 rdy_en_q;             // holds ready low until after reset release

   logic                 xfer;
   logic                 wr_en;
   logic [IDX_WIDTH-1:0] wr_addr;

   // ---------------------------------------------------------------
   // Stream handshake
   // ---------------------------------------------------------------
   assign s_tready = rdy_en_q && (state_q != PENDING);
   assign xfer     = s_tvalid && s_tready;

   // ---------------------------------------------------------------
   // Loader FSM
   // ---------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         wr_idx_q    <= '0;
         bank_q      <= 1'b0;
         pal_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         bank_q      <= bank_d;
         pal_valid_q <= pal_valid_d;
         err_q       <= err_d;
         rdy_en_q    <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      bank_d      = bank_q;
      pal_valid_d = pal_valid_q;
      err_d       = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = wr_idx_q;

      unique case (state_q)
         IDLE: begin
            wr_addr = '0;
            if (xfer) begin
               wr_en    = 1'b1;
               wr_idx_d = IDX_WIDTH'(1);
               if (s_tlast && (MAX_ITERATION > 1)) begin
                  // a one-entry palette is only legal when the depth is one
                  err_d    = 1'b1;
                  wr_idx_d = '0;
                  state_d  = IDLE;
               end else if (s_tlast) begin
                  state_d = PENDING;
               end else begin
                  state_d = LOAD;
               end
            end
         end

         LOAD: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (wr_idx_q == LAST_IDX) begin
                  if (s_tlast) begin
                     state_d = PENDING;
                  end else begin
                     // too long: keep what we have, swallow the rest
                     err_d   = 1'b1;
                     state_d = DRAIN;
                  end
               end else if (s_tlast) begin
                  err_d    = 1'b1;
                  wr_idx_d = '0;
                  state_d  = IDLE;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end

         DRAIN: begin
            if (xfer && s_tlast) begin
               wr_idx_d = '0;
               state_d  = IDLE;
            end
         end

         PENDING: begin
            if (frame_sync) begin
               bank_d      = ~bank_q;
               pal_valid_d = 1'b1;
               wr_idx_d    = '0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign palette_valid = pal_valid_q;
   assign load_busy     = (state_q != IDLE);
   assign load_error    = err_q;

   // ---------------------------------------------------------------
   // Palette banks: writes always target the shadow bank
   // ---------------------------------------------------------------
   logic [IDX_WIDTH-1:0] raddr [NUM_ENGINES];
   logic [NUM_ENGINES-1:0] oor;
   logic [RGB_SIZE-1:0]  rd0 [NUM_ENGINES];
   logic [RGB_SIZE-1:0]  rd1 [NUM_ENGINES];

   always_comb begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
         // full-width compare so large counts never alias into the table
         oor[i]   = (iterations[i] >= MAX_ITER_W);
         raddr[i] = oor[i] ? '0 : iterations[i][IDX_WIDTH-1:0];
      end
   end

   palette_bank #(
      .RGB_SIZE (RGB_SIZE),
      .DEPTH    (MAX_ITERATION),
      .NUM_RD   (NUM_ENGINES),
      .AW       (IDX_WIDTH)
   ) u_bank0 (
      .clk_i   (aclk),
      .we_i    (wr_en && bank_q),
      .waddr_i (wr_addr),
      .wdata_i (s_tdata),
      .raddr_i (raddr),
      .rdata_o (rd0)
   );

   palette_bank #(
      .RGB_SIZE (RGB_SIZE),
      .DEPTH    (MAX_ITERATION),
      .NUM_RD   (NUM_ENGINES),
      .AW       (IDX_WIDTH)
   ) u_bank1 (
      .clk_i   (aclk),
      .we_i    (wr_en && !bank_q),
      .waddr_i (wr_addr),
      .wdata_i (s_tdata),
      .raddr_i (raddr),
      .rdata_o (rd1)
   );

   // ---------------------------------------------------------------
   // Read-side qualifiers, aligned with the registered bank outputs.
   // Sampling bank_q here means a lookup in the swap cycle sees the old bank.
   // ---------------------------------------------------------------
   logic                   rd_bank_q;
   logic                   rd_valid_q;
   logic [NUM_ENGINES-1:0] oor_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_bank_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         oor_q      <= '0;
      end else begin
         rd_bank_q  <= bank_q;
         rd_valid_q <= pal_valid_q;
         oor_q      <= oor;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
         rgb_val[i] = '0;
         if (rd_valid_q) begin
            if (oor_q[i]) rgb_val[i] = INSIDE_COLOUR;
            else          rgb_val[i] = rd_bank_q ? rd1[i] : rd0[i];
         end
      end
   end

endmodule

// File: doc/palette_loader.md
Name: palette_loader

Overview:
Runtime writer for the iteration-to-colour palette that the pixel engines read.
- Accepts palette entries from the host over a valid/ready stream and writes them into a double-buffered palette RAM.
- Commits a new palette only at a frame boundary, so engines never see a half-written palette.
- Serves NUM_ENGINES parallel registered lookups, replacing the static hex-loaded table.

Parameters:
DATA_WIDTH, 32, width of each engine iteration count
RGB_SIZE, 24, palette entry width (8:8:8 RGB)
MAX_ITERATION, 50, palette depth; valid indices 0..MAX_ITERATION-1
NUM_ENGINES, 3, number of parallel lookup ports
INSIDE_COLOUR, 24'h000000, colour returned for iterations >= MAX_ITERATION
IDX_WIDTH, $clog2(MAX_ITERATION), localparam, write-index width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_tdata  in  RGB_SIZE  palette entry
s_tvalid  in  1  entry valid
s_tready  out  1  loader ready
s_tlast  in  1  marks final entry of a palette
frame_sync  in  1  one-cycle frame-boundary strobe
iterations  in  DATA_WIDTH x NUM_ENGINES  lookup indices, unpacked array
rgb_val  out  RGB_SIZE x NUM_ENGINES  looked-up colours, unpacked array
palette_valid  out  1  a complete palette has been committed
load_busy  out  1  high in LOAD, DRAIN or PENDING
load_error  out  1  one-cycle pulse on a malformed palette

Behaviour:
- Reset values (async assert, sync release):
  - s_tready=0 while aresetn low; 1 from the first cycle after release.
  - rgb_val all 0, palette_valid=0, load_busy=0, load_error=0.
  - active_bank=0, wr_idx=0, state=IDLE. RAM contents are not reset.
- Handshake:
  - A beat transfers when s_tvalid && s_tready.
  - s_tready = (state in IDLE, LOAD, DRAIN).
  - s_tdata/s_tlast are sampled only on a transfer.
- Writes go to bank ~active_bank at address wr_idx.
- FSM:
  - IDLE: a transfer writes entry 0 and sets wr_idx=1.
    - If s_tlast and MAX_ITERATION>1: error, go to IDLE.
    - Otherwise go to LOAD, or to PENDING if MAX_ITERATION==1 and s_tlast.
  - LOAD: each transfer writes at wr_idx, then wr_idx++.
    - s_tlast with wr_idx==MAX_ITERATION-1: go to PENDING.
    - s_tlast with wr_idx<MAX_ITERATION-1 (short palette): load_error pulse, wr_idx=0, go to IDLE.
    - Beat at wr_idx==MAX_ITERATION-1 without s_tlast (long palette): load_error pulse, go to DRAIN.
  - DRAIN: accept and discard beats with no write; on s_tlast go to IDLE with wr_idx=0.
  - PENDING: s_tready=0. On frame_sync: active_bank flips, palette_valid=1, wr_idx=0, go to IDLE (flip visible next cycle).
- frame_sync outside PENDING is ignored.
- On any error the shadow bank may be partially overwritten; active_bank is untouched and never swapped.
- Read path, 1-cycle latency:
  - rgb_val[i] at cycle n+1 = palette[active_bank][iterations[i]] as sampled at cycle n.
  - If iterations[i] >= MAX_ITERATION: INSIDE_COLOUR. Compare the full DATA_WIDTH value; no truncation.
  - If palette_valid==0: 0.
  - A lookup issued in the same cycle as the swapping frame_sync uses the old bank.
- Write and read never hit the same bank, so there are no read-during-write hazards.
- aresetn asserted mid-load: everything returns to reset state, including palette_valid=0.

Decomposition:
- Package mandel_pkg holds:
  - rgb_t typedef (logic [RGB_SIZE-1:0])
  - loader_state_t enum {IDLE, LOAD, DRAIN, PENDING}
  - INSIDE_COLOUR default
- Sub-module palette_bank: one write port and NUM_ENGINES registered read ports, depth MAX_ITERATION. Instantiated twice; read outputs are muxed by a registered copy of active_bank.

Test Plan:
- Reset, then iterations={0,10,49} -> rgb_val all 0 and palette_valid=0; s_tready=1 one cycle after aresetn rises.
- Stream 50 entries (entry k = 24'h010000*k + k, tlast on beat 49), no frame_sync -> s_tready=0, load_busy=1, rgb_val still 0. Pulse frame_sync -> palette_valid=1. Two cycles later iterations={0,10,49} -> rgb_val={000000,0A000A,31_0031} (24'h310031).
- With that palette committed, iterations={50,1000,32'hFFFF_FFFF} -> rgb_val all INSIDE_COLOUR.
- Short palette, tlast on beat 20 -> one load_error pulse, state IDLE, old palette still returned; a later frame_sync causes no swap.
- Long palette, 60 beats with tlast on beat 59 -> load_error pulse at beat 49, beats 50-59 accepted with s_tready=1, back to IDLE, no swap.
- Assert aresetn low during beat 25 of a load -> all outputs return to reset values and palette_valid=0; a fresh 50-entry load plus frame_sync then succeeds.
